issue_scheduler: RTL and testbench

- Dual-issue in-order scheduler that drives the `issue_i[1:0]` pop port of the 2-entry decode-side instruction buffer.
- Inspects both buffered slots, checks a per-register scoreboard, intra-pair dependencies and structural limits, and asserts issue for slot0, slot0+1, or neither.
- Sits between the instruction buffer and the register-read stage.
- Owns the scoreboard update for issued writers and for writeback/flush events.

---
 rtl/issue_scheduler_pkg.sv | 36 +++
 rtl/issue_scheduler_if.sv | 32 +++
 rtl/issue_scoreboard.sv | 89 ++++++++
 rtl/issue_scheduler.sv | 108 ++++++++++
 tb/tb_issue_scheduler.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/issue_scheduler_pkg.sv
// Shared types and constants for the dual-issue scheduler slice.
package issue_pkg;

    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned CNT_W_DEF = 3;

    // Counter value meaning "result arrives only via load writeback".
    localparam logic [CNT_W_DEF-1:0] LONG = '1;

    typedef enum logic [1:0] {
        CLS_ALU    = 2'd0,
        CLS_MUL    = 2'd1,
        CLS_MEM    = 2'd2,
        CLS_BRANCH = 2'd3
    } pipe_class_e;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
        logic [REG_IDX_W-1:0] rd;
        logic                 we;
        pipe_class_e          cls;
        logic                 load;
    } slot_info_t;

    localparam logic [1:0] RSN_NONE   = 2'd0;
    localparam logic [1:0] RSN_RAW    = 2'd1;
    localparam logic [1:0] RSN_STRUCT = 2'd2;
    localparam logic [1:0] RSN_EXT    = 2'd3;

    // A slot that updates architectural state other than r0.
    function automatic logic is_writer(input slot_info_t s);
        return s.we && (s.rd != '0);
    endfunction

endpackage

// File: rtl/issue_scheduler_if.sv
// Instruction-buffer / writeback / control bundle seen by the issue scheduler.
interface issue_scheduler_if;
    import issue_pkg::*;

    logic                      flush_i;
    logic                      stall_i;
    logic                      dual_en_i;
    logic [1:0]                slot_valid_i;
    logic [1:0][REG_IDX_W-1:0] slot_rs1_i;
    logic [1:0][REG_IDX_W-1:0] slot_rs2_i;
    logic [1:0][REG_IDX_W-1:0] slot_rd_i;
    logic [1:0]                slot_we_i;
    logic [1:0][1:0]           slot_class_i;
    logic [1:0]                slot_load_i;
    logic                      wb_valid_i;
    logic [REG_IDX_W-1:0]      wb_rd_i;
    logic [1:0]                issue_o;
    logic [1:0]                stall_reason_o;

    modport master (
        output flush_i, stall_i, dual_en_i, slot_valid_i, slot_rs1_i, slot_rs2_i,
               slot_rd_i, slot_we_i, slot_class_i, slot_load_i, wb_valid_i, wb_rd_i,
        input  issue_o, stall_reason_o
    );

    modport slave (
        input  flush_i, stall_i, dual_en_i, slot_valid_i, slot_rs1_i, slot_rs2_i,
               slot_rd_i, slot_we_i, slot_class_i, slot_load_i, wb_valid_i, wb_rd_i,
        output issue_o, stall_reason_o
    );

endinterface

// File: rtl/issue_scoreboard.sv
// Per-register readiness counters plus busy lookups for the two buffered slots.
module issue_scoreboard
    import issue_pkg::*;
#(
    parameter int unsigned REG_NUM = 32,
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 stall,
    input  logic                 wb_valid,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  slot_info_t [1:0]     slot,
    input  logic [1:0]           issue,
    output logic [1:0]           src_busy,
    output logic [1:0]           rd_long
);

    localparam logic [CNT_W-1:0] CNT_LONG = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] MUL_SET  = CNT_W'(MUL_LAT - 1);

    logic [CNT_W-1:0] cnt_q [REG_NUM];
    logic [CNT_W-1:0] cnt_d [REG_NUM];
    logic [1:0]       set_en;
    logic [CNT_W-1:0] set_val [2];

    // Counter value each issued slot writes into its destination.
    always_comb begin
        for (int unsigned s = 0; s < 2; s++) begin
            set_en[s]  = issue[s] && is_writer(slot[s]);
            set_val[s] = '0;
            if (slot[s].cls == CLS_MUL) begin
                set_val[s] = MUL_SET;
            end else if (slot[s].cls == CLS_MEM && slot[s].load) begin
                set_val[s] = CNT_LONG;
            end
        end
    end

    // Next counter state: flush > issue-set (slot1 last) > wb-clear > decrement.
    always_comb begin
        for (int unsigned r = 0; r < REG_NUM; r++) begin
            cnt_d[r] = cnt_q[r];
            if (flush) begin
                cnt_d[r] = '0;
            end else begin
                if (!stall && cnt_q[r] != '0 && cnt_q[r] != CNT_LONG) begin
                    cnt_d[r] = cnt_q[r] - 1'b1;
                end
                if (wb_valid && wb_rd == REG_IDX_W'(r)) begin
                    cnt_d[r] = '0;
                end
                for (int unsigned s = 0; s < 2; s++) begin
                    if (!stall && set_en[s] && slot[s].rd == REG_IDX_W'(r)) begin
                        cnt_d[r] = set_val[s];
                    end
                end
            end
            if (r == 0) begin
                cnt_d[r] = '0;
            end
        end
    end

    // Counter array register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < REG_NUM; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < REG_NUM; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    // Source and destination lookups; r0 reads never block.
    always_comb begin
        for (int unsigned s = 0; s < 2; s++) begin
            src_busy[s] = (slot[s].rs1 != '0 && cnt_q[slot[s].rs1] != '0) ||
                          (slot[s].rs2 != '0 && cnt_q[slot[s].rs2] != '0);
            rd_long[s]  = (cnt_q[slot[s].rd] == CNT_LONG);
        end
    end

endmodule

// File: rtl/issue_scheduler.sv
// Dual-issue in-order scheduler for the 2-entry decode buffer.
// Optional feature macro: ISSUE_SCHED_PERF_EN (adds dual/single/RAW-stall counters on perf_o).
module issue_scheduler
    import issue_pkg::*;
#(
    parameter int unsigned REG_NUM = 32,
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    issue_scheduler_if.slave bus,
    output logic [2:0][31:0] perf_o
);

    slot_info_t [1:0] slot;
    logic [1:0]       src_busy;
    logic [1:0]       rd_long;
    logic [1:0]       sb_ok;
    logic [1:0]       issue;
    logic [1:0]       reason;
    logic             pair_raw;
    logic             pair_waw;
    logic             pair_struct;

    // Collect the flat buffer fields into per-slot records.
    always_comb begin
        slot = '0;
        for (int unsigned s = 0; s < 2; s++) begin
            slot[s].rs1  = bus.slot_rs1_i[s];
            slot[s].rs2  = bus.slot_rs2_i[s];
            slot[s].rd   = bus.slot_rd_i[s];
            slot[s].we   = bus.slot_we_i[s];
            slot[s].cls  = pipe_class_e'(bus.slot_class_i[s]);
            slot[s].load = bus.slot_load_i[s];
        end
    end

    issue_scoreboard #(
        .REG_NUM (REG_NUM),
        .MUL_LAT (MUL_LAT),
        .CNT_W   (CNT_W)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (bus.flush_i),
        .stall    (bus.stall_i),
        .wb_valid (bus.wb_valid_i),
        .wb_rd    (bus.wb_rd_i),
        .slot     (slot),
        .issue    (issue),
        .src_busy (src_busy),
        .rd_long  (rd_long)
    );

    // Pairing rules and issue decision.
    always_comb begin
        for (int unsigned s = 0; s < 2; s++) begin
            sb_ok[s] = !src_busy[s] && !(slot[s].we && rd_long[s]);
        end
        pair_raw    = is_writer(slot[0]) &&
                      (slot[1].rs1 == slot[0].rd || slot[1].rs2 == slot[0].rd);
        pair_waw    = is_writer(slot[0]) && is_writer(slot[1]) && (slot[0].rd == slot[1].rd);
        pair_struct = (slot[0].cls == CLS_MEM && slot[1].cls == CLS_MEM) ||
                      (slot[0].cls == CLS_MUL && slot[1].cls == CLS_MUL) ||
                      (slot[0].cls == CLS_BRANCH);
        issue    = '0;
        issue[0] = rst_n && bus.slot_valid_i[0] && !bus.stall_i && !bus.flush_i && sb_ok[0];
        issue[1] = issue[0] && bus.dual_en_i && bus.slot_valid_i[1] && sb_ok[1] &&
                   !pair_raw && !pair_waw && !pair_struct;
    end

    // Slot0 blocking cause, external first.
    always_comb begin
        if (!rst_n || !bus.slot_valid_i[0] || issue[0]) begin
            reason = RSN_NONE;
        end else if (bus.stall_i || bus.flush_i) begin
            reason = RSN_EXT;
        end else if (!sb_ok[0]) begin
            reason = RSN_RAW;
        end else begin
            reason = RSN_STRUCT;
        end
    end

    assign bus.issue_o        = issue;
    assign bus.stall_reason_o = reason;

`ifdef ISSUE_SCHED_PERF_EN
    logic [2:0][31:0] perf_q;

    // Free-running event counters; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else begin
            if (issue == 2'b11) perf_q[0] <= perf_q[0] + 32'd1;
            if (issue == 2'b01) perf_q[1] <= perf_q[1] + 32'd1;
            if (reason == RSN_RAW) perf_q[2] <= perf_q[2] + 32'd1;
        end
    end

    assign perf_o = perf_q;
`else
    assign perf_o = '0;
`endif

endmodule

// File: tb/tb_issue_scheduler.sv
// Bench for issue_scheduler: directed scenarios plus random traffic vs a readiness-time model.
module tb_issue_scheduler;
    import issue_pkg::*;

    localparam int unsigned MUL_LAT = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [2:0][31:0] perf_o;

    issue_scheduler_if bus ();

    issue_scheduler #(
        .REG_NUM (32),
        .MUL_LAT (MUL_LAT),
        .CNT_W   (3)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .perf_o (perf_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: a register is ready once the count of unstalled edges reaches rdy[r],
    // or never while a load to it is outstanding (pend[r]).
    bit          pend [32];
    int unsigned rdy  [32];
    int unsigned act;
    int unsigned m_dual, m_single, m_raw;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            pend[i] = 1'b0;
            rdy[i]  = 0;
        end
        act      = 0;
        m_dual   = 0;
        m_single = 0;
        m_raw    = 0;
    endfunction

    function automatic bit busy(input logic [4:0] r);
        return (r != 5'd0) && (pend[r] || rdy[r] > act);
    endfunction

    function automatic void pred(output logic [1:0] iss, output logic [1:0] rsn);
        bit ok [2];
        bit raw_p, waw_p, st_p;
        for (int s = 0; s < 2; s++) begin
            ok[s] = !busy(bus.slot_rs1_i[s]) && !busy(bus.slot_rs2_i[s]) &&
                    !(bus.slot_we_i[s] && bus.slot_rd_i[s] != 5'd0 && pend[bus.slot_rd_i[s]]);
        end
        raw_p = bus.slot_we_i[0] && bus.slot_rd_i[0] != 5'd0 &&
                (bus.slot_rs1_i[1] == bus.slot_rd_i[0] || bus.slot_rs2_i[1] == bus.slot_rd_i[0]);
        waw_p = bus.slot_we_i[0] && bus.slot_we_i[1] && bus.slot_rd_i[0] != 5'd0 &&
                bus.slot_rd_i[0] == bus.slot_rd_i[1];
        st_p  = (bus.slot_class_i[0] == 2'd2 && bus.slot_class_i[1] == 2'd2) ||
                (bus.slot_class_i[0] == 2'd1 && bus.slot_class_i[1] == 2'd1) ||
                (bus.slot_class_i[0] == 2'd3);
        iss    = 2'b00;
        iss[0] = rst_n && bus.slot_valid_i[0] && !bus.stall_i && !bus.flush_i && ok[0];
        iss[1] = iss[0] && bus.dual_en_i && bus.slot_valid_i[1] && ok[1] && !raw_p && !waw_p && !st_p;
        if (!rst_n || !bus.slot_valid_i[0] || iss[0]) rsn = 2'd0;
        else if (bus.stall_i || bus.flush_i)          rsn = 2'd3;
        else                                          rsn = 2'd1;
    endfunction

    function automatic void model_edge(input logic [1:0] iss, input logic [1:0] rsn);
        if (iss == 2'b11) m_dual++;
        else if (iss == 2'b01) m_single++;
        if (rsn == 2'd1) m_raw++;
        if (bus.flush_i) begin
            for (int i = 0; i < 32; i++) begin
                pend[i] = 1'b0;
                rdy[i]  = 0;
            end
            return;
        end
        if (bus.wb_valid_i) begin
            pend[bus.wb_rd_i] = 1'b0;
            rdy[bus.wb_rd_i]  = 0;
        end
        if (!bus.stall_i) begin
            for (int s = 0; s < 2; s++) begin
                if (iss[s] && bus.slot_we_i[s] && bus.slot_rd_i[s] != 5'd0) begin
                    if (bus.slot_class_i[s] == 2'd1) begin
                        pend[bus.slot_rd_i[s]] = 1'b0;
                        rdy[bus.slot_rd_i[s]]  = act + MUL_LAT;
                    end else if (bus.slot_class_i[s] == 2'd2 && bus.slot_load_i[s]) begin
                        pend[bus.slot_rd_i[s]] = 1'b1;
                    end else begin
                        pend[bus.slot_rd_i[s]] = 1'b0;
                        rdy[bus.slot_rd_i[s]]  = 0;
                    end
                end
            end
            act++;
        end
    endfunction

    task automatic tick();
        logic [1:0] pi, pr;
        pred(pi, pr);
        @(posedge clk);
        model_edge(pi, pr);
        #1;
    endtask

    task automatic put(input int s, input bit v, input int cls, input int rd,
                       input int rs1, input int rs2, input bit we, input bit ld);
        bus.slot_valid_i[s] = v;
        bus.slot_class_i[s] = 2'(cls);
        bus.slot_rd_i[s]    = 5'(rd);
        bus.slot_rs1_i[s]   = 5'(rs1);
        bus.slot_rs2_i[s]   = 5'(rs2);
        bus.slot_we_i[s]    = we;
        bus.slot_load_i[s]  = ld;
    endtask

    task automatic idle();
        put(0, 0, 0, 0, 0, 0, 0, 0);
        put(1, 0, 0, 0, 0, 0, 0, 0);
        bus.flush_i    = 1'b0;
        bus.stall_i    = 1'b0;
        bus.dual_en_i  = 1'b1;
        bus.wb_valid_i = 1'b0;
        bus.wb_rd_i    = 5'd0;
    endtask

    task automatic expect_out(input string tag, input logic [1:0] ei, input logic [1:0] er);
        #1;
        chk({tag, "_issue"}, 32'(bus.issue_o), 32'(ei));
        chk({tag, "_reason"}, 32'(bus.stall_reason_o), 32'(er));
    endtask

    initial begin
        logic [1:0] pi, pr;
        int         cls, r;

        rst_n = 1'b0;
        idle();
        model_reset();
        put(0, 1, 0, 1, 2, 3, 1, 0);
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset", 2'b00, 2'b00);
        chk("reset_perf", perf_o[0] | perf_o[1] | perf_o[2], 32'd0);
        rst_n = 1'b1;
        idle();
        @(posedge clk);
        #1;

        // Independent ALU pair
        put(0, 1, 0, 1, 2, 3, 1, 0);
        put(1, 1, 0, 4, 5, 6, 1, 0);
        expect_out("indep", 2'b11, 2'b00);
        tick();

        // Intra-pair RAW, then consumer moves to slot0
        put(1, 1, 0, 7, 1, 2, 1, 0);
        expect_out("pair_raw", 2'b01, 2'b00);
        tick();
        put(0, 1, 0, 7, 1, 2, 1, 0);
        put(1, 0, 0, 0, 0, 0, 0, 0);
        expect_out("raw_next", 2'b01, 2'b00);
        tick();

        // Load-use waits for writeback
        put(0, 1, 2, 5, 2, 0, 1, 1);
        expect_out("ld_issue", 2'b01, 2'b00);
        tick();
        put(0, 1, 0, 6, 5, 0, 1, 0);
        expect_out("ld_use0", 2'b00, 2'b01);
        tick();
        expect_out("ld_use1", 2'b00, 2'b01);
        tick();
        bus.wb_valid_i = 1'b1;
        bus.wb_rd_i    = 5'd5;
        expect_out("ld_wb", 2'b00, 2'b01);
        tick();
        bus.wb_valid_i = 1'b0;
        expect_out("ld_after_wb", 2'b01, 2'b00);
        tick();

        // MUL latency
        put(0, 1, 1, 8, 1, 2, 1, 0);
        expect_out("mul_t", 2'b01, 2'b00);
        tick();
        put(0, 1, 0, 9, 8, 0, 1, 0);
        expect_out("mul_t1", 2'b00, 2'b01);
        tick();
        expect_out("mul_t2", 2'b00, 2'b01);
        tick();
        expect_out("mul_t3", 2'b01, 2'b00);
        tick();

        // MUL latency with one stalled cycle
        put(0, 1, 1, 8, 1, 2, 1, 0);
        expect_out("mulst_t", 2'b01, 2'b00);
        tick();
        put(0, 1, 0, 9, 8, 0, 1, 0);
        expect_out("mulst_t1", 2'b00, 2'b01);
        tick();
        bus.stall_i = 1'b1;
        expect_out("mulst_t2", 2'b00, 2'b11);
        tick();
        bus.stall_i = 1'b0;
        expect_out("mulst_t3", 2'b00, 2'b01);
        tick();
        expect_out("mulst_t4", 2'b01, 2'b00);
        tick();

        // Structural limits
        put(0, 1, 2, 10, 1, 0, 1, 1);
        put(1, 1, 2, 11, 2, 0, 1, 1);
        expect_out("two_mem", 2'b01, 2'b00);
        tick();
        bus.dual_en_i = 1'b0;
        put(0, 1, 0, 12, 1, 2, 1, 0);
        put(1, 1, 0, 13, 3, 4, 1, 0);
        expect_out("no_dual", 2'b01, 2'b00);
        tick();
        bus.dual_en_i = 1'b1;
        put(0, 1, 3, 0, 1, 2, 0, 0);
        put(1, 1, 0, 14, 3, 4, 1, 0);
        expect_out("branch0", 2'b01, 2'b00);
        tick();
        put(0, 1, 1, 15, 1, 2, 1, 0);
        put(1, 1, 1, 16, 3, 4, 1, 0);
        expect_out("two_mul", 2'b01, 2'b00);
        tick();
        put(0, 1, 0, 17, 1, 2, 1, 0);
        put(1, 1, 0, 17, 3, 4, 1, 0);
        expect_out("pair_waw", 2'b01, 2'b00);
        tick();
        put(0, 1, 0, 0, 1, 2, 1, 0);
        put(1, 1, 0, 23, 0, 0, 1, 0);
        expect_out("r0_pair", 2'b11, 2'b00);
        tick();
        put(1, 0, 0, 0, 0, 0, 0, 0);

        // Flush kills pending loads (r9 now, r10 from the MEM pair)
        put(0, 1, 2, 9, 1, 0, 1, 1);
        expect_out("fl_ld", 2'b01, 2'b00);
        tick();
        put(0, 1, 0, 18, 9, 10, 1, 0);
        bus.flush_i = 1'b1;
        expect_out("fl_cycle", 2'b00, 2'b11);
        tick();
        bus.flush_i = 1'b0;
        expect_out("fl_after", 2'b01, 2'b00);
        tick();

        // New load wins over same-cycle writeback
        put(0, 1, 2, 3, 1, 0, 1, 1);
        bus.wb_valid_i = 1'b1;
        bus.wb_rd_i    = 5'd3;
        expect_out("coll_ld", 2'b01, 2'b00);
        tick();
        bus.wb_valid_i = 1'b0;
        put(0, 1, 0, 1, 3, 0, 1, 0);
        expect_out("coll_use", 2'b00, 2'b01);
        tick();
        bus.wb_valid_i = 1'b1;
        expect_out("coll_wb", 2'b00, 2'b01);
        tick();
        bus.wb_valid_i = 1'b0;
        expect_out("coll_done", 2'b01, 2'b00);
        tick();

        // WAW against a pending load
        put(0, 1, 2, 20, 1, 0, 1, 1);
        expect_out("waw_ld", 2'b01, 2'b00);
        tick();
        put(0, 1, 0, 20, 1, 2, 1, 0);
        expect_out("waw_blk", 2'b00, 2'b01);
        tick();

        // Asynchronous reset mid-operation clears the pending r20 load
        rst_n = 1'b0;
        put(0, 1, 0, 21, 1, 2, 1, 0);
        expect_out("arst_low", 2'b00, 2'b00);
        model_reset();
        rst_n = 1'b1;
        put(0, 1, 0, 22, 20, 0, 1, 0);
        expect_out("arst_rel", 2'b01, 2'b00);
        tick();

        // Random traffic against the model
        for (int n = 0; n < 800; n++) begin
            for (int s = 0; s < 2; s++) begin
                cls = int'($urandom_range(0, 3));
                put(s, ($urandom_range(0, 9) != 0), cls, int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                    (cls == 3) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 4) != 0),
                    (cls == 2) ? $urandom_range(0, 1) : 0);
                if (cls == 2 && !bus.slot_load_i[s]) bus.slot_we_i[s] = 1'b0;
            end
            bus.dual_en_i  = ($urandom_range(0, 4) != 0);
            bus.stall_i    = ($urandom_range(0, 9) == 0);
            bus.flush_i    = ($urandom_range(0, 24) == 0);
            bus.wb_valid_i = ($urandom_range(0, 3) == 0);
            r = int'($urandom_range(1, 7));
            if (!pend[r]) r = int'($urandom_range(0, 7));
            bus.wb_rd_i = 5'(r);
            #1;
            pred(pi, pr);
            chk("rand_issue", 32'(bus.issue_o), 32'(pi));
            chk("rand_reason", 32'(bus.stall_reason_o), 32'(pr));
            tick();
        end

`ifdef ISSUE_SCHED_PERF_EN
        chk("perf_dual", perf_o[0], m_dual);
        chk("perf_single", perf_o[1], m_single);
        chk("perf_raw", perf_o[2], m_raw);
`else
        chk("perf_off", perf_o[0] | perf_o[1] | perf_o[2], 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
